msj_update_scheduler: RTL
=========================

MSJ_UPDATE_SCHEDULER -- requirements
Module: msj_update_scheduler

Interface
REQ-001 Parameter NUM_MOTORS, default 4: number of motors sharing one PD controller datapath.
REQ-002 Parameter SETTLE, default 2: cycles sel is held with update_controller low before triggering; legal range is at least 1.
REQ-003 Parameter LATENCY, default 3: cycles update_controller is held high before ctrl_duty is captured; legal range is at least 2.
REQ-004 clock  in  1  system clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 enable  in  1  permits new rounds to start.
REQ-007 motor_mask  in  NUM_MOTORS  bit i=1 means motor i is serviced.
REQ-008 update_period  in  32  unsigned cycles between round start ticks; 0 is treated as 1.
REQ-009 ctrl_duty  in  32 signed  duty result from the shared PD controller.
REQ-010 sel  out  $clog2(NUM_MOTORS)  motor index steering the shared controller's sp/position/velocity/gain muxes.
REQ-011 update_controller  out  1  update strobe to the shared controller, which acts on its rising edge.
REQ-012 duty  out  32*NUM_MOTORS  per-motor duty; motor i at [32i+31:32i].
REQ-013 duty_valid  out  NUM_MOTORS  1-cycle pulse when duty slice i updates.
REQ-014 busy  out  1  high in every non-IDLE state.
REQ-015 round_done  out  1  1-cycle pulse at end of round.
REQ-016 overrun  out  1  sticky flag: a tick arrived while busy.
REQ-017 overrun_clear  in  1  synchronous clear of overrun.

Function
REQ-018 Period counter: while enable is low it SHALL be 0. While enable is high and it equals 0, it SHALL assert tick and load max(update_period,1)-1. Otherwise it SHALL decrement. It runs independently of FSM state.
REQ-019 FSM states SHALL be IDLE, SETTLE, WAIT, CAPTURE.
REQ-020 IDLE + tick + (motor_mask!=0): latch motor_mask, set sel to the lowest set bit, go to SETTLE. IDLE + tick with mask==0: stay IDLE, no outputs change.
REQ-021 SETTLE SHALL last SETTLE cycles with update_controller=0, then go to WAIT.
REQ-022 WAIT SHALL last LATENCY cycles with update_controller=1, then go to CAPTURE.
REQ-023 CAPTURE (1 cycle, update_controller=0): duty[sel]<=ctrl_duty and duty_valid[sel]<=1, both visible the next cycle. If a higher-index latched mask bit exists, sel moves to it and the FSM goes to SETTLE. Otherwise it goes to IDLE with round_done=1 for that first IDLE cycle.
REQ-024 Slot length SHALL be SETTLE+LATENCY+1 cycles (6 at defaults). A tick at cycle t with k enabled motors gives round_done at t+1+k*(SETTLE+LATENCY+1).
REQ-025 sel SHALL be stable throughout SETTLE, WAIT and CAPTURE of a slot.
REQ-026 motor_mask changes mid-round SHALL take effect next round only.
REQ-027 Deasserting enable mid-round SHALL let the current round complete; no further rounds start.
REQ-028 A tick while busy SHALL be dropped; the round is not restarted or queued.
REQ-029 Duty slices of unserviced motors SHALL hold their values.
REQ-030 overrun_clear coincident with a new overrun event: set wins.

Reset
REQ-031 Asynchronous reset SHALL force: FSM=IDLE, counter=0, sel=0, update_controller=0, duty=all 0, duty_valid=0, busy=0, round_done=0, overrun=0, latched mask=0.
REQ-032 Reset mid-round SHALL abort immediately; after release, operation resumes with a fresh tick on the first enabled cycle.

Configuration
REQ-033 Macro MSJ_SCHED_OVERRUN_EN defined: overrun logic per REQ-016/REQ-028/REQ-030 is compiled in. Undefined: overrun is tied to 0 and overrun_clear is ignored; tick dropping is unchanged.

Verification
REQ-034 Defaults, mask=4'b1111, update_period=100, ctrl_duty=sel*10+5: duty={35,25,15,5}; duty_valid pulses 6 cycles apart; round_done at t+25; next round at t+100; overrun=0.
REQ-035 mask=4'b0101, same stimulus: only slices 0 and 2 update (5, 25); slices 1 and 3 hold; round_done at t+13.
REQ-036 update_period=10, mask=4'b1111, MSJ_SCHED_OVERRUN_EN defined: overrun=1 after the second tick, rounds still complete every 25+ cycles; overrun_clear pulse -> overrun=0, then it re-sets on the next dropped tick. Without the macro, overrun stays 0.
REQ-037 Check update_controller per slot: low for exactly 2 cycles, then high for exactly 3, then low for 1; exactly one rising edge per serviced motor.
REQ-038 Assert reset at cycle t+10 of a round: all outputs reach reset values asynchronously. After release, with enable=1, the round restarts from motor 0 with a slot-0 rising edge at tick+3.
REQ-039 Change mask from 4'b1111 to 4'b0001 mid-round: the current round services all 4 motors; the next round services motor 0 only.

Source files
------------

// File: rtl/msj_update_scheduler.sv
// Time-multiplexes one shared PD controller across NUM_MOTORS motors, one settle/update/capture slot per motor.
// Optional overrun detection is compiled in with MSJ_SCHED_OVERRUN_EN.
module msj_update_scheduler #(
    parameter int NUM_MOTORS = 4,
    parameter int SETTLE     = 2,
    parameter int LATENCY    = 3,
    localparam int SW = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [NUM_MOTORS-1:0]   motor_mask,
    input  logic [31:0]             update_period,
    input  logic [31:0]             ctrl_duty,
    output logic [SW-1:0]           sel,
    output logic                    update_controller,
    output logic [32*NUM_MOTORS-1:0] duty,
    output logic [NUM_MOTORS-1:0]   duty_valid,
    output logic                    busy,
    output logic                    round_done,
    output logic                    overrun,
    input  logic                    overrun_clear,
    output logic [1:0]              state_dbg
);

    localparam int PW = $clog2(SETTLE + LATENCY + 1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_WAIT, S_CAPTURE} state_t;

    state_t                  state;
    logic [31:0]             period_cnt;
    logic                    tick;
    logic [NUM_MOTORS-1:0]   mask_q;
    logic [PW-1:0]           phase;
    logic [SW-1:0]           first_sel;
    logic [SW-1:0]           next_sel;
    logic                    next_found;

    assign tick      = enable && (period_cnt == 32'd0);
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    // Free-running period counter; a period of 0 behaves like 1 (tick every cycle).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            period_cnt <= 32'd0;
        end else if (!enable) begin
            period_cnt <= 32'd0;
        end else if (period_cnt == 32'd0) begin
            period_cnt <= (update_period == 32'd0) ? 32'd0 : update_period - 32'd1;
        end else begin
            period_cnt <= period_cnt - 32'd1;
        end
    end

    // Lowest set bit of the live mask, and the next latched bit above sel.
    always_comb begin
        first_sel  = '0;
        next_found = 1'b0;
        next_sel   = sel;
        for (int i = NUM_MOTORS - 1; i >= 0; i--) begin
            if (motor_mask[i]) first_sel = SW'(i);
            if (mask_q[i] && (i > int'(sel))) begin
                next_found = 1'b1;
                next_sel   = SW'(i);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= S_IDLE;
            sel               <= '0;
            update_controller <= 1'b0;
            duty              <= '0;
            duty_valid        <= '0;
            round_done        <= 1'b0;
            mask_q            <= '0;
            phase             <= '0;
        end else begin
            duty_valid <= '0;
            round_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tick && (motor_mask != '0)) begin
                        mask_q <= motor_mask;
                        sel    <= first_sel;
                        phase  <= '0;
                        state  <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (phase == PW'(SETTLE - 1)) begin
                        phase             <= '0;
                        update_controller <= 1'b1;
                        state             <= S_WAIT;
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                S_WAIT: begin
                    if (phase == PW'(LATENCY - 1)) begin
                        phase             <= '0;
                        update_controller <= 1'b0;
                        state             <= S_CAPTURE;
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                S_CAPTURE: begin
                    for (int i = 0; i < NUM_MOTORS; i++) begin
                        if (i == int'(sel)) begin
                            duty[32*i +: 32] <= ctrl_duty;
                            duty_valid[i]    <= 1'b1;
                        end
                    end
                    if (next_found) begin
                        sel   <= next_sel;
                        state <= S_SETTLE;
                    end else begin
                        round_done <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MSJ_SCHED_OVERRUN_EN
    // A new overrun event takes priority over a coincident clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (tick && busy) begin
            overrun <= 1'b1;
        end else if (overrun_clear) begin
            overrun <= 1'b0;
        end
    end
`else
    logic unused_overrun_clear;
    assign unused_overrun_clear = overrun_clear;
    assign overrun = 1'b0;
`endif

endmodule
